// File: rtl/any1_pkg.sv
`default_nettype none
// any1_pkg: shared value/point types and transform-scheduler state encoding.
package any1_pkg;

  typedef logic [31:0] Value;

  typedef struct packed {
    Value x;
    Value y;
    Value z;
  } Point;

  localparam int XFS_TAGW = 4;
  localparam int XFS_ADRW = 6;

  typedef logic [XFS_TAGW-1:0] xfs_tag_t;

  typedef enum logic [1:0] {
    XFS_RUN   = 2'd0,
    XFS_DRAIN = 2'd1,
    XFS_CFG   = 2'd2,
    XFS_ACK   = 2'd3
  } xfs_state_t;

endpackage
`default_nettype wire

// File: rtl/any1_xfsched_fifo.sv
`default_nettype none
// any1_xfsched_fifo: result FIFO for the transform scheduler.
// Revision: 1.0
module any1_xfsched_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push onto a full FIFO is legal when the same cycle pops.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule
`default_nettype wire

// File: rtl/any1_xform_sched.sv
`default_nettype none
// any1_xform_sched: arbitrates CPU/graphics point requests onto a shared transform unit.
// Define ANY1_XFSCHED_ROUNDROBIN_EN for round-robin arbitration (default: requester 0 fixed priority).
module any1_xform_sched
  import any1_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int TAGW       = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  Point [1:0]           req_pt_i,
  input  logic [1:0][TAGW-1:0] req_tag_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output Point                 rsp_pt_o,
  output logic                 rsp_id_o,
  output logic [TAGW-1:0]      rsp_tag_o,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [5:0]           cfg_adr_i,
  input  Value                 cfg_dat_i,
  output logic                 cfg_ack_o,
  output Value                 cfg_dat_o,
  output logic                 xf_wr_o,
  output logic [5:0]           xf_adr_o,
  output Value                 xf_dat_o,
  input  Value                 xf_dat_i,
  output Point                 xf_pt_o,
  input  Point                 xf_pt_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 1 + TAGW + $bits(Point);

  xfs_state_t      state;
  xfs_state_t      state_nx;
  logic            prefer;
  logic            gnt_id;
  logic            can_accept;
  logic            grant;
  logic            inflight;
  logic            infl_id;
  logic [TAGW-1:0] infl_tag;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occupancy;
  logic [EW-1:0]   fifo_head;

  assign pop = rsp_valid_o && rsp_ready_i;

  // Credit: the point in the transform plus stored results, minus a pop this cycle.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};

  assign can_accept = !rst_i && (state == XFS_RUN) && !cfg_req_i &&
                      (!fifo_full || pop) && (occupancy < (CW+1)'(FIFO_DEPTH));

`ifdef ANY1_XFSCHED_ROUNDROBIN_EN
  logic rr_ptr;

  always_ff @(posedge clk_i) begin
    if (rst_i)      rr_ptr <= 1'b0;
    else if (grant) rr_ptr <= ~gnt_id;
  end

  assign prefer = rr_ptr;
`else
  assign prefer = 1'b0;
`endif

  always_comb begin
    gnt_id = prefer;
    if (!req_valid_i[prefer] && req_valid_i[~prefer]) gnt_id = ~prefer;
  end

  assign grant       = can_accept && req_valid_i[gnt_id];
  assign req_ready_o = can_accept ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign xf_pt_o     = req_pt_i[gnt_id];

  // Side pipeline: id/tag travel alongside the point through the 1-cycle transform.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight <= 1'b0;
      infl_id  <= 1'b0;
      infl_tag <= '0;
    end else begin
      inflight <= grant;
      infl_id  <= gnt_id;
      infl_tag <= req_tag_i[gnt_id];
    end
  end

  any1_xfsched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (inflight),
    .push_dat ({infl_id, infl_tag, xf_pt_i}),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign {rsp_id_o, rsp_tag_o, rsp_pt_o} = fifo_head;
  assign rsp_valid_o = !fifo_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= XFS_RUN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      XFS_RUN:   if (cfg_req_i) state_nx = XFS_DRAIN;
      XFS_DRAIN: if (!inflight) state_nx = XFS_CFG;
      XFS_CFG:   state_nx = XFS_ACK;
      XFS_ACK:   state_nx = XFS_RUN;
      default:   state_nx = XFS_RUN;
    endcase
  end

  // Transform-unit config port is loaded on the edge entering CFG so it is valid during CFG.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xf_wr_o   <= 1'b0;
      xf_adr_o  <= '0;
      xf_dat_o  <= '0;
      cfg_dat_o <= '0;
    end else begin
      xf_wr_o <= 1'b0;
      if (state == XFS_DRAIN && !inflight) begin
        xf_wr_o  <= cfg_we_i;
        xf_adr_o <= cfg_adr_i;
        xf_dat_o <= cfg_dat_i;
      end
      if (state == XFS_CFG) cfg_dat_o <= xf_dat_i;
    end
  end

  assign cfg_ack_o = (state == XFS_ACK);

endmodule
`default_nettype wire

// File: tb/tb_any1_xform_sched.sv
`default_nettype none
// tb_any1_xform_sched: directed self-checking bench with a behavioural transform unit.
module tb_any1_xform_sched;
  import any1_pkg::*;

  localparam int FIFO_DEPTH = 2;
  localparam int TAGW       = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  Point [1:0]           req_pt;
  logic [1:0][TAGW-1:0] req_tag;
  logic                 rsp_valid;
  logic                 rsp_ready;
  Point                 rsp_pt;
  logic                 rsp_id;
  logic [TAGW-1:0]      rsp_tag;
  logic                 cfg_req;
  logic                 cfg_we;
  logic [5:0]           cfg_adr;
  Value                 cfg_dat;
  logic                 cfg_ack;
  Value                 cfg_rdat;
  logic                 xf_wr;
  logic [5:0]           xf_adr;
  Value                 xf_wdat;
  Value                 xf_rdat;
  Point                 xf_pt_out;
  Point                 xf_pt_in;

  int checks = 0;
  int errors = 0;

  Value xregs [64];

  always #5 clk = ~clk;

  any1_xform_sched #(.FIFO_DEPTH(FIFO_DEPTH), .TAGW(TAGW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_pt_i(req_pt), .req_tag_i(req_tag),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_pt_o(rsp_pt),
    .rsp_id_o(rsp_id), .rsp_tag_o(rsp_tag),
    .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_adr_i(cfg_adr), .cfg_dat_i(cfg_dat),
    .cfg_ack_o(cfg_ack), .cfg_dat_o(cfg_rdat),
    .xf_wr_o(xf_wr), .xf_adr_o(xf_adr), .xf_dat_o(xf_wdat), .xf_dat_i(xf_rdat),
    .xf_pt_o(xf_pt_out), .xf_pt_i(xf_pt_in)
  );

  function automatic Point mkpt(input Value x, input Value y, input Value z);
    Point p;
    p.x = x; p.y = y; p.z = z;
    return p;
  endfunction

  // Transform unit: registered (x+100, y+200, z+reg[3]); config regs read combinationally.
  always @(posedge clk) begin
    if (rst) for (int k = 0; k < 64; k++) xregs[k] <= '0;
    else if (xf_wr) xregs[xf_adr] <= xf_wdat;
    xf_pt_in <= mkpt(xf_pt_out.x + 32'd100, xf_pt_out.y + 32'd200, xf_pt_out.z + xregs[3]);
  end

  assign xf_rdat = xregs[xf_adr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req_valid = 2'b00; rsp_ready = 1'b0;
    req_pt[0] = mkpt(0, 0, 0); req_pt[1] = mkpt(0, 0, 0);
    req_tag[0] = '0; req_tag[1] = '0;
    cfg_req = 1'b0; cfg_we = 1'b0; cfg_adr = '0; cfg_dat = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_cfg(input logic we, input logic [5:0] adr, input Value dat,
                        output logic got, output Value rd);
    got = 1'b0; rd = '0;
    cfg_req = 1'b1; cfg_we = we; cfg_adr = adr; cfg_dat = dat;
    for (int n = 0; n < 8 && !got; n++) begin
      #1;
      if (cfg_ack) begin got = 1'b1; rd = cfg_rdat; end
      tick();
    end
    cfg_req = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    req_valid = 2'b11;
    tick();
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (cfg_ack !== 1'b0) begin errors++; $display("FAIL reset_cfg_ack: got %b expected 0", cfg_ack); end
    checks++; if (xf_wr !== 1'b0) begin errors++; $display("FAIL reset_xf_wr: got %b expected 0", xf_wr); end
    checks++; if (cfg_rdat !== 32'd0) begin errors++; $display("FAIL reset_cfg_dat: got %h expected 0", cfg_rdat); end
    tick();
    rst = 1'b0;
    req_valid = 2'b00;
  endtask

  task automatic test_single;
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 2'b01; req_pt[0] = mkpt(1, 2, 3); req_tag[0] = 4'd5;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    checks++; if (xf_pt_out !== mkpt(1, 2, 3)) begin errors++; $display("FAIL single_xf_pt: got %h expected %h", xf_pt_out, mkpt(1, 2, 3)); end
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", rsp_valid); end
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id: got %b expected 0", rsp_id); end
    checks++; if (rsp_tag !== 4'd5) begin errors++; $display("FAIL single_tag: got %h expected 5", rsp_tag); end
    checks++; if (rsp_pt !== mkpt(101, 202, 3)) begin errors++; $display("FAIL single_pt: got %h expected %h", rsp_pt, mkpt(101, 202, 3)); end
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_popped: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_arbitration;
    logic [1:0] exp_rdy;
    logic       exp_id [4];
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 2'b11; req_tag[0] = 4'h1; req_tag[1] = 4'h2;
    for (int i = 0; i < 4; i++) begin
`ifdef ANY1_XFSCHED_ROUNDROBIN_EN
      exp_rdy = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
      exp_rdy = 2'b01;
`endif
      exp_id[i] = exp_rdy[1];
      #1;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL arb_grant%0d: got %b expected %b", i, req_ready, exp_rdy); end
      if (i >= 2) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id[i-2]) begin errors++; $display("FAIL arb_rsp%0d: got valid %b id %b expected valid 1 id %b", i, rsp_valid, rsp_id, exp_id[i-2]); end
      end
      tick();
    end
    req_valid = 2'b00;
    for (int i = 2; i < 4; i++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id[i]) begin errors++; $display("FAIL arb_tail%0d: got valid %b id %b expected valid 1 id %b", i, rsp_valid, rsp_id, exp_id[i]); end
      tick();
    end
  endtask

  task automatic test_backpressure;
    logic rdy_pat [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic exp_rdy [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      req_valid = 2'b01; req_tag[0] = 4'(i); rsp_ready = rdy_pat[i];
      #1;
      checks++; if (req_ready[0] !== exp_rdy[i]) begin errors++; $display("FAIL bp_ready%0d: got %b expected %b", i, req_ready[0], exp_rdy[i]); end
      if (i == 4) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'd0) begin errors++; $display("FAIL bp_pop_tag: got valid %b tag %h expected valid 1 tag 0", rsp_valid, rsp_tag); end
      end
      tick();
    end
    req_valid = 2'b00; rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'd1) begin errors++; $display("FAIL bp_drain0: got valid %b tag %h expected valid 1 tag 1", rsp_valid, rsp_tag); end
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'd4) begin errors++; $display("FAIL bp_drain1: got valid %b tag %h expected valid 1 tag 4", rsp_valid, rsp_tag); end
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_cfg_write;
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 2'b01; req_pt[0] = mkpt(10, 20, 30); req_tag[0] = 4'd7;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL cw_first_grant: got %b expected 01", req_ready); end
    tick();
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_adr = 6'd3; cfg_dat = 32'h0001_0000;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL cw_cfg_priority: got %b expected 00", req_ready); end
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_pt !== mkpt(110, 220, 30)) begin errors++; $display("FAIL cw_drain_rsp: got valid %b pt %h expected valid 1 pt %h", rsp_valid, rsp_pt, mkpt(110, 220, 30)); end
    checks++; if (req_ready !== 2'b00 || xf_wr !== 1'b0 || cfg_ack !== 1'b0) begin errors++; $display("FAIL cw_drain: got ready %b wr %b ack %b expected 00 0 0", req_ready, xf_wr, cfg_ack); end
    tick();
    #1;
    checks++; if (xf_wr !== 1'b1 || xf_adr !== 6'd3 || xf_wdat !== 32'h0001_0000) begin errors++; $display("FAIL cw_cfg_write: got wr %b adr %0d dat %h expected 1 3 00010000", xf_wr, xf_adr, xf_wdat); end
    checks++; if (req_ready !== 2'b00 || cfg_ack !== 1'b0) begin errors++; $display("FAIL cw_cfg_state: got ready %b ack %b expected 00 0", req_ready, cfg_ack); end
    tick();
    #1;
    checks++; if (cfg_ack !== 1'b1 || xf_wr !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL cw_ack: got ack %b wr %b ready %b expected 1 0 00", cfg_ack, xf_wr, req_ready); end
    tick();
    cfg_req = 1'b0; cfg_we = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01 || cfg_ack !== 1'b0) begin errors++; $display("FAIL cw_run: got ready %b ack %b expected 01 0", req_ready, cfg_ack); end
    tick();
    req_valid = 2'b00;
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_pt !== mkpt(110, 220, 65566)) begin errors++; $display("FAIL cw_new_xform: got valid %b pt %h expected valid 1 pt %h", rsp_valid, rsp_pt, mkpt(110, 220, 65566)); end
    tick();
  endtask

  task automatic test_cfg_read;
    logic got;
    Value rd;
    do_cfg(1'b1, 6'd31, 32'd1, got, rd);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL cr_write_ack: got %b expected 1", got); end
    do_cfg(1'b0, 6'd31, 32'd0, got, rd);
    checks++; if (got !== 1'b1 || rd !== 32'd1) begin errors++; $display("FAIL cr_read: got ack %b dat %h expected ack 1 dat 00000001", got, rd); end
  endtask

  task automatic test_reset_mid;
    logic bad;
    do_reset();
    req_valid = 2'b01; req_tag[0] = 4'd9;
    tick();
    tick();
    req_valid = 2'b00;
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_adr = 6'd3; cfg_dat = 32'd5;
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b1 || cfg_ack !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL rm_pre: got valid %b ack %b ready %b expected 1 0 00", rsp_valid, cfg_ack, req_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0; cfg_req = 1'b0; cfg_we = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (req_ready !== 2'b01 || xf_wr !== 1'b0) begin errors++; $display("FAIL rm_run: got ready %b wr %b expected 01 0", req_ready, xf_wr); end
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cfg_ack !== 1'b0 || xf_wr !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rm_no_ack: got stray ack/write %b expected 0", bad); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_backpressure();
    test_cfg_write();
    test_cfg_read();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
